// File: rtl/eth_switch_nxn.sv
`default_nettype none
// ============================================================================
// eth_switch_nxn : NxN packet switch, per-input FIFOs, per-output RR arbiters
// Revision       : 1.0 - initial release
// ============================================================================
module eth_switch_nxn #(
  parameter int NPORTS = 2,
  parameter int DW     = 32,
  parameter int DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS*DW-1:0] in_data,
  input  logic [NPORTS-1:0]    in_valid,
  input  logic [NPORTS-1:0]    in_sop,
  input  logic [NPORTS-1:0]    in_eop,
  output logic [NPORTS-1:0]    in_stall,
  output logic [NPORTS*DW-1:0] out_data,
  output logic [NPORTS-1:0]    out_valid,
  output logic [NPORTS-1:0]    out_sop,
  output logic [NPORTS-1:0]    out_eop,
  input  logic [NPORTS-1:0]    out_ready,
  output logic [NPORTS*8-1:0]  drop_cnt
);

  localparam int PW = $clog2(NPORTS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DW + 2;
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // FIFO entry layout: {sop, eop, data}
  logic [EW-1:0]     mem_q     [NPORTS][DEPTH];
  logic [AW-1:0]     wr_ptr_q  [NPORTS];
  logic [AW-1:0]     wr_ptr_d  [NPORTS];
  logic [AW-1:0]     rd_ptr_q  [NPORTS];
  logic [AW-1:0]     rd_ptr_d  [NPORTS];
  logic [CW-1:0]     cnt_q     [NPORTS];
  logic [CW-1:0]     cnt_d     [NPORTS];
  logic [7:0]        drop_q    [NPORTS];
  logic [7:0]        drop_d    [NPORTS];
  logic [NPORTS-1:0] open_q;
  logic [NPORTS-1:0] open_d;
  logic [NPORTS-1:0] wr_en;
  logic [NPORTS-1:0] rd_en;
  logic [EW-1:0]     head_word [NPORTS];
  logic [NPORTS-1:0] head_vld;
  logic [NPORTS-1:0] sop_req   [NPORTS];

  arb_state_t        state_q   [NPORTS];
  arb_state_t        state_d   [NPORTS];
  logic [PW-1:0]     owner_q   [NPORTS];
  logic [PW-1:0]     owner_d   [NPORTS];
  logic [PW-1:0]     rr_q      [NPORTS];
  logic [PW-1:0]     rr_d      [NPORTS];
  logic [DW-1:0]     odata_q   [NPORTS];
  logic [DW-1:0]     odata_d   [NPORTS];
  logic [NPORTS-1:0] ov_q, ov_d;
  logic [NPORTS-1:0] osop_q, osop_d;
  logic [NPORTS-1:0] oeop_q, oeop_d;
  logic [NPORTS-1:0] load_ok;
  logic [NPORTS-1:0] arb_found;
  logic [NPORTS-1:0] arb_xfer;
  logic [PW-1:0]     arb_src   [NPORTS];
  logic [PW-1:0]     cand;

  // FIFO heads and the per-output request matrix (sop words by destination)
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      head_word[i] = mem_q[i][rd_ptr_q[i]];
      head_vld[i]  = (cnt_q[i] != '0);
    end
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        sop_req[o][i] = head_vld[i] && head_word[i][EW-1] &&
                        (head_word[i][PW-1:0] == PW'(o));
      end
    end
  end

  always_comb begin
    rd_en = '0;
    cand  = '0;
    for (int o = 0; o < NPORTS; o++) begin
      arb_found[o] = 1'b0;
      arb_src[o]   = owner_q[o];
      state_d[o]   = state_q[o];
      owner_d[o]   = owner_q[o];
      rr_d[o]      = rr_q[o];
      ov_d[o]      = ov_q[o];
      osop_d[o]    = osop_q[o];
      oeop_d[o]    = oeop_q[o];
      odata_d[o]   = odata_q[o];
      if (state_q[o] == ARB_IDLE) begin
        for (int k = 0; k < NPORTS; k++) begin
          cand = rr_q[o] + PW'(k);
          if (!arb_found[o] && sop_req[o][cand]) begin
            arb_found[o] = 1'b1;
            arb_src[o]   = cand;
          end
        end
      end
      load_ok[o]  = !ov_q[o] || out_ready[o];
      arb_xfer[o] = load_ok[o] &&
                    ((state_q[o] == ARB_IDLE) ? arb_found[o] : head_vld[owner_q[o]]);
      if (arb_xfer[o]) begin
        rd_en[arb_src[o]] = 1'b1;
        ov_d[o]    = 1'b1;
        osop_d[o]  = head_word[arb_src[o]][EW-1];
        oeop_d[o]  = head_word[arb_src[o]][EW-2];
        odata_d[o] = head_word[arb_src[o]][DW-1:0];
        if (state_q[o] == ARB_IDLE) begin
          rr_d[o] = arb_src[o] + PW'(1);
          // a one-word packet is fully moved in the grant cycle, so no lock
          if (!head_word[arb_src[o]][EW-2]) begin
            state_d[o] = ARB_LOCKED;
            owner_d[o] = arb_src[o];
          end
        end else if (head_word[arb_src[o]][EW-2]) begin
          state_d[o] = ARB_IDLE;
        end
      end else if (load_ok[o]) begin
        ov_d[o] = 1'b0;
      end
    end
  end

  // Accept only legal framing; after any accepted word the packet is open iff no eop
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      in_stall[i]  = (cnt_q[i] >= STALL_LVL);
      wr_en[i]     = in_valid[i] && !in_stall[i] && (in_sop[i] ? !open_q[i] : open_q[i]);
      wr_ptr_d[i]  = wr_ptr_q[i] + AW'(wr_en[i]);
      rd_ptr_d[i]  = rd_ptr_q[i] + AW'(rd_en[i]);
      cnt_d[i]     = cnt_q[i] + CW'(wr_en[i]) - CW'(rd_en[i]);
      open_d[i]    = wr_en[i] ? !in_eop[i] : open_q[i];
      drop_d[i]    = drop_q[i];
      if (in_valid[i] && !wr_en[i] && (drop_q[i] != 8'hFF)) begin
        drop_d[i] = drop_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (wr_en[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {in_sop[i], in_eop[i], in_data[i*DW +: DW]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      open_q <= '0;
      ov_q   <= '0;
      osop_q <= '0;
      oeop_q <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        drop_q[i]   <= '0;
        state_q[i]  <= ARB_IDLE;
        owner_q[i]  <= '0;
        rr_q[i]     <= '0;
        odata_q[i]  <= '0;
      end
    end else begin
      open_q <= open_d;
      ov_q   <= ov_d;
      osop_q <= osop_d;
      oeop_q <= oeop_d;
      for (int i = 0; i < NPORTS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
        drop_q[i]   <= drop_d[i];
        state_q[i]  <= state_d[i];
        owner_q[i]  <= owner_d[i];
        rr_q[i]     <= rr_d[i];
        odata_q[i]  <= odata_d[i];
      end
    end
  end

  assign out_valid = ov_q;
  assign out_sop   = osop_q;
  assign out_eop   = oeop_q;

  generate
    for (genvar g = 0; g < NPORTS; g++) begin : g_pack
      assign out_data[g*DW +: DW] = odata_q[g];
      assign drop_cnt[g*8 +: 8]   = drop_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_eth_switch_nxn.sv
`default_nettype none
// ============================================================================
// tb_eth_switch_nxn : directed checks on a 2-port switch, random traffic on 4x4
// Revision          : 1.0 - initial release
// ============================================================================
module tb_eth_switch_nxn;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // 2-port instance, default geometry
  logic        a_reset;
  logic [63:0] a_in_data;
  logic [1:0]  a_in_valid, a_in_sop, a_in_eop, a_in_stall;
  logic [63:0] a_out_data;
  logic [1:0]  a_out_valid, a_out_sop, a_out_eop, a_out_ready;
  logic [15:0] a_drop_cnt;

  // 4-port instance with shallow FIFOs
  logic         b_reset;
  logic [127:0] b_in_data;
  logic [3:0]   b_in_valid, b_in_sop, b_in_eop, b_in_stall;
  logic [127:0] b_out_data;
  logic [3:0]   b_out_valid, b_out_sop, b_out_eop, b_out_ready;
  logic [31:0]  b_drop_cnt;

  eth_switch_nxn #(.NPORTS(2), .DW(32), .DEPTH(16)) dut_a (
    .clk(clk), .reset(a_reset),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_sop(a_in_sop), .in_eop(a_in_eop),
    .in_stall(a_in_stall),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_sop(a_out_sop), .out_eop(a_out_eop),
    .out_ready(a_out_ready), .drop_cnt(a_drop_cnt)
  );

  eth_switch_nxn #(.NPORTS(4), .DW(32), .DEPTH(4)) dut_b (
    .clk(clk), .reset(b_reset),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_sop(b_in_sop), .in_eop(b_in_eop),
    .in_stall(b_in_stall),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_sop(b_out_sop), .out_eop(b_out_eop),
    .out_ready(b_out_ready), .drop_cnt(b_drop_cnt)
  );

  word_t a_sq  [2][$];
  word_t a_exp [2][$];
  word_t a_cap [2][$];
  word_t b_exp [16][$];
  int    b_rem [4];
  int    b_idx [4];
  int    b_cur [4];
  logic [1:0] b_dst [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t mkword(int k, int n, logic [31:0] base, int dest);
    word_t w;
    w.sop     = (k == 0);
    w.eop     = (k == n - 1);
    w.data    = base + 32'(k << 4);
    w.data[0] = dest[0];
    return w;
  endfunction

  task automatic push_pkt(int port, int dest, int n, logic [31:0] base);
    for (int k = 0; k < n; k++) a_sq[port].push_back(mkword(k, n, base, dest));
  endtask

  task automatic expect_pkt(int dest, int n, logic [31:0] base);
    for (int k = 0; k < n; k++) a_exp[dest].push_back(mkword(k, n, base, dest));
  endtask

  task automatic push_raw(int port, logic sop, logic eop, logic [31:0] data);
    word_t w;
    w.sop = sop; w.eop = eop; w.data = data;
    a_sq[port].push_back(w);
  endtask

  // capture outputs handed over this cycle, drive next input words, advance one edge
  task automatic a_cycle();
    word_t w;
    for (int o = 0; o < 2; o++) begin
      if (a_out_valid[o] && a_out_ready[o]) begin
        w.sop = a_out_sop[o]; w.eop = a_out_eop[o]; w.data = a_out_data[o*32 +: 32];
        a_cap[o].push_back(w);
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (a_sq[p].size() > 0) begin
        w = a_sq[p].pop_front();
        a_in_valid[p] = 1'b1; a_in_sop[p] = w.sop; a_in_eop[p] = w.eop;
        a_in_data[p*32 +: 32] = w.data;
      end else begin
        a_in_valid[p] = 1'b0; a_in_sop[p] = 1'b0; a_in_eop[p] = 1'b0;
      end
    end
    tick();
  endtask

  task automatic compare_out(int o, string tag);
    int n;
    check({tag, "_count"}, 64'(a_cap[o].size()), 64'(a_exp[o].size()));
    n = (a_cap[o].size() < a_exp[o].size()) ? a_cap[o].size() : a_exp[o].size();
    for (int k = 0; k < n; k++) check({tag, "_word"}, 64'(a_cap[o][k]), 64'(a_exp[o][k]));
    a_cap[o].delete();
    a_exp[o].delete();
  endtask

  task automatic a_reset_pulse();
    a_reset = 1'b1;
    a_in_valid = '0; a_in_sop = '0; a_in_eop = '0;
    for (int p = 0; p < 2; p++) begin
      a_sq[p].delete(); a_exp[p].delete(); a_cap[p].delete();
    end
    tick();
    tick();
    a_reset = 1'b0;
  endtask

  task automatic check_a_idle(string tag);
    check({tag, "_valid"}, 64'(a_out_valid), 64'd0);
    check({tag, "_flags"}, 64'({a_out_sop, a_out_eop}), 64'd0);
    check({tag, "_data"},  a_out_data, 64'd0);
    check({tag, "_stall"}, 64'(a_in_stall), 64'd0);
    check({tag, "_drops"}, 64'(a_drop_cnt), 64'd0);
  endtask

  initial begin
    int  occ;
    int  exp_drops;
    bit  reg_full;
    bit  acc;
    bit  fwd;
    bit  gen_on;
    int  src;
    int  qi;
    word_t w;
    word_t e;

    a_reset = 1'b1; b_reset = 1'b1;
    a_in_data = '0; a_in_valid = '0; a_in_sop = '0; a_in_eop = '0; a_out_ready = '0;
    b_in_data = '0; b_in_valid = '0; b_in_sop = '0; b_in_eop = '0; b_out_ready = '0;
    tick();
    tick();
    check_a_idle("reset_a");
    check("reset_b_valid", 64'(b_out_valid), 64'd0);
    check("reset_b_data",  64'(b_out_data == '0), 64'd1);
    check("reset_b_stall", 64'(b_in_stall), 64'd0);
    check("reset_b_drops", 64'(b_drop_cnt), 64'd0);
    a_reset = 1'b0;
    b_reset = 1'b0;

    // 3-word packet 0 -> 1 with exact first-word latency
    a_out_ready = 2'b11;
    push_pkt(0, 1, 3, 32'h0000_1000);
    expect_pkt(1, 3, 32'h0000_1000);
    a_cycle();
    check("lat_before", 64'(a_out_valid), 64'd0);
    a_cycle();
    check("lat_valid", 64'(a_out_valid), 64'b10);
    check("lat_sop",   64'(a_out_sop[1]), 64'd1);
    check("lat_data",  64'(a_out_data[63:32]), 64'(mkword(0, 3, 32'h0000_1000, 1).data));
    repeat (5) a_cycle();
    compare_out(1, "basic");
    check("basic_o0_quiet", 64'(a_cap[0].size()), 64'd0);

    // contention on output 0: A(p0), B(p1) start together, C(p0) queued behind A
    a_reset_pulse();
    a_out_ready = 2'b11;
    push_pkt(0, 0, 4, 32'h0000_2000);
    push_pkt(0, 0, 2, 32'h0000_3000);
    push_pkt(1, 0, 4, 32'h0000_4000);
    expect_pkt(0, 4, 32'h0000_2000);
    expect_pkt(0, 4, 32'h0000_4000);
    expect_pkt(0, 2, 32'h0000_3000);
    repeat (20) a_cycle();
    compare_out(0, "rr");
    check("rr_o1_quiet", 64'(a_cap[1].size()), 64'd0);
    a_cap[1].delete();

    // backpressure: output 0 blocked, port 0 streams one long open packet
    a_reset_pulse();
    a_out_ready = 2'b10;
    occ = 0; exp_drops = 0; reg_full = 1'b0;
    for (int k = 0; k < 22; k++) begin
      check("bp_stall", 64'(a_in_stall[0]), 64'(occ >= 15));
      a_in_valid[0] = 1'b1;
      a_in_sop[0]   = (k == 0);
      a_in_eop[0]   = 1'b0;
      a_in_data[31:0] = 32'h0000_5000 + 32'(k << 4);
      acc = (occ < 15);
      if (!acc) exp_drops++;
      fwd = !reg_full && (occ > 0);
      occ = occ + int'(acc) - int'(fwd);
      if (fwd) reg_full = 1'b1;
      tick();
    end
    a_in_valid = '0;
    check("bp_drops", 64'(a_drop_cnt[7:0]), 64'(exp_drops));
    check("bp_drops_p1", 64'(a_drop_cnt[15:8]), 64'd0);
    check("bp_stall_p1", 64'(a_in_stall[1]), 64'd0);
    a_reset_pulse();
    check_a_idle("bp_reset");

    // framing errors: two orphans, then a packet with a stray sop in the middle
    a_out_ready = 2'b11;
    push_raw(0, 1'b0, 1'b0, 32'h0000_5010);
    push_raw(0, 1'b0, 1'b1, 32'h0000_5021);
    push_raw(0, 1'b1, 1'b0, 32'h0000_6001);
    push_raw(0, 1'b0, 1'b0, 32'h0000_6011);
    push_raw(0, 1'b1, 1'b0, 32'h0000_7001);
    push_raw(0, 1'b0, 1'b1, 32'h0000_6021);
    e.sop = 1'b1; e.eop = 1'b0; e.data = 32'h0000_6001; a_exp[1].push_back(e);
    e.sop = 1'b0; e.eop = 1'b0; e.data = 32'h0000_6011; a_exp[1].push_back(e);
    e.sop = 1'b0; e.eop = 1'b1; e.data = 32'h0000_6021; a_exp[1].push_back(e);
    repeat (12) a_cycle();
    check("frame_drops", 64'(a_drop_cnt), 64'd3);
    compare_out(1, "frame");
    check("frame_o0_quiet", 64'(a_cap[0].size()), 64'd0);

    // reset mid-packet after two words have left the switch
    a_reset_pulse();
    a_out_ready = 2'b11;
    push_pkt(0, 1, 5, 32'h0000_8000);
    for (int k = 0; k < 10; k++) begin
      if (a_cap[1].size() < 2) a_cycle();
    end
    check("mid_two_fwd", 64'(a_cap[1].size()), 64'd2);
    a_reset = 1'b1;
    a_sq[0].delete();
    a_in_valid = '0; a_in_sop = '0; a_in_eop = '0;
    #1;
    check_a_idle("mid_rst");
    tick();
    check_a_idle("mid_rst_hold");
    a_reset = 1'b0;
    a_cap[0].delete(); a_cap[1].delete();
    push_pkt(0, 1, 3, 32'h0000_9000);
    expect_pkt(1, 3, 32'h0000_9000);
    repeat (10) a_cycle();
    compare_out(1, "mid_after");
    check("mid_o0_quiet", 64'(a_cap[0].size()), 64'd0);

    // 4x4 random legal traffic against a per-(output,input) packet scoreboard
    for (int s = 0; s < 4; s++) begin
      b_rem[s] = 0; b_idx[s] = 0; b_cur[s] = -1; b_dst[s] = 2'd0;
    end
    for (int t = 0; t < 3000; t++) begin
      gen_on = (t < 2700);
      for (int o = 0; o < 4; o++) b_out_ready[o] = ($urandom_range(0, 3) != 0);
      for (int o = 0; o < 4; o++) begin
        if (b_out_valid[o] && b_out_ready[o]) begin
          w.sop = b_out_sop[o]; w.eop = b_out_eop[o]; w.data = b_out_data[o*32 +: 32];
          if (b_cur[o] < 0) begin
            check("b_pkt_starts_sop", 64'(w.sop), 64'd1);
            src = int'(w.data[3:2]);
          end else begin
            src = b_cur[o];
          end
          qi = o * 4 + src;
          check("b_word_expected", 64'(b_exp[qi].size() != 0), 64'd1);
          if (b_exp[qi].size() != 0) begin
            e = b_exp[qi].pop_front();
            check("b_word", 64'(w), 64'(e));
          end
          b_cur[o] = w.eop ? -1 : src;
        end
      end
      for (int s = 0; s < 4; s++) begin
        if (b_rem[s] == 0 && gen_on && $urandom_range(0, 3) != 0) begin
          b_rem[s] = $urandom_range(1, 5);
          b_idx[s] = 0;
          b_dst[s] = 2'($urandom_range(0, 3));
        end
        b_in_valid[s] = 1'b0; b_in_sop[s] = 1'b0; b_in_eop[s] = 1'b0;
        if (b_rem[s] > 0 && !b_in_stall[s] && $urandom_range(0, 3) != 0) begin
          w.sop = (b_idx[s] == 0);
          w.eop = (b_rem[s] == 1);
          w.data = $urandom();
          w.data[1:0] = b_dst[s];
          w.data[3:2] = 2'(s);
          b_in_valid[s] = 1'b1; b_in_sop[s] = w.sop; b_in_eop[s] = w.eop;
          b_in_data[s*32 +: 32] = w.data;
          b_exp[int'(b_dst[s]) * 4 + s].push_back(w);
          b_idx[s]++;
          b_rem[s]--;
        end
      end
      tick();
    end
    b_in_valid = '0;
    for (int q = 0; q < 16; q++) check("b_drained", 64'(b_exp[q].size()), 64'd0);
    check("b_no_drops", 64'(b_drop_cnt), 64'd0);
    check("b_outputs_idle", 64'(b_out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
